stack_dump: RTL and testbench

//  Reader-side counterpart to the push-driven stack demo: on a start request, pops
//  the stack one entry at a time until it is empty, holding each entry on a display
//  bus for a fixed dwell. Sits between the stack's pop/rd_data/uf side and the sseg

---
 rtl/stack_dump_pkg.sv | 16 +
 rtl/stack_dump_dwell_timer.sv | 42 ++++
 rtl/stack_dump.sv | 174 +++++++++++++++++
 tb/tb_stack_dump.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/stack_dump_pkg.sv
// Shared state encoding and helpers for the stack dump reader.
package stack_dump_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SHOW   = 3'd1,
      ST_POP    = 3'd2,
      ST_SETTLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic logic is_busy(input state_e st);
      return (st == ST_SHOW) || (st == ST_POP) || (st == ST_SETTLE);
   endfunction

endpackage

// File: rtl/stack_dump_dwell_timer.sv
// Dwell timer: counts enabled cycles from a clear, saturating at HOLD_TICKS-1,
// and flags the final enabled cycle of the dwell.
module dwell_timer #(
   parameter int HOLD_TICKS = 50_000_000,
   parameter int HOLD_CW    = 26
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [HOLD_CW-1:0] LAST_CNT = HOLD_CW'(HOLD_TICKS - 1);

   logic [HOLD_CW-1:0] cnt_q;
   logic [HOLD_CW-1:0] cnt_d;

   // next count: clear wins, otherwise count up and park at the last tick
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST_CNT)) begin
         cnt_d = cnt_q + HOLD_CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/stack_dump.sv
// Stack dump reader: pops an external stack entry by entry, showing each for a fixed dwell.
// Optional build macro STACK_DUMP_COUNT_EN adds the item_cnt output (pops issued this dump).
module stack_dump #(
   parameter int DW         = 8,
   parameter int HOLD_TICKS = 50_000_000,
   parameter int HOLD_CW    = 26,
   parameter int CNT_W      = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [DW-1:0] stk_rd_data,
   input  logic          stk_uf,
   output logic          stk_pop,
   output logic [DW-1:0] disp_data,
   output logic          disp_valid,
   output logic          busy,
   output logic          done
`ifdef STACK_DUMP_COUNT_EN
   ,
   output logic [CNT_W-1:0] item_cnt
`endif
);

   import stack_dump_pkg::*;

   if ((HOLD_TICKS < 1) || (CNT_W < 1) || ((64'd1 << HOLD_CW) <= 64'(HOLD_TICKS))) begin : g_param_err
      $error("stack_dump: illegal HOLD_TICKS/HOLD_CW/CNT_W combination");
   end

   state_e        state_q;
   state_e        state_d;
   logic [DW-1:0] disp_q;
   logic [DW-1:0] disp_d;
   logic          valid_q;
   logic          valid_d;
   logic          tmr_clr_s;
   logic          tmr_en_s;
   logic          tmr_expire_s;
   logic          pop_s;

   dwell_timer #(
      .HOLD_TICKS (HOLD_TICKS),
      .HOLD_CW    (HOLD_CW)
   ) u_dwell (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (tmr_clr_s),
      .en_i     (tmr_en_s),
      .expire_o (tmr_expire_s)
   );

   // next-state and datapath control; abort beats every busy-state action
   always_comb begin
      state_d   = state_q;
      disp_d    = disp_q;
      valid_d   = valid_q;
      tmr_clr_s = 1'b0;
      tmr_en_s  = 1'b0;
      pop_s     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && !abort) begin
               tmr_clr_s = 1'b1;
               if (stk_uf) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
               end else begin
                  state_d = ST_SHOW;
                  disp_d  = stk_rd_data;
                  valid_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHOW: begin
            tmr_en_s = 1'b1;
            if (abort) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (tmr_expire_s) begin
               state_d = ST_POP;
            end else begin
               state_d = ST_SHOW;
            end
         end
         ST_POP: begin
            // stk_uf is re-checked here in case someone else drained the stack
            if (abort) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (stk_uf) begin
               state_d = ST_DONE;
            end else begin
               pop_s   = 1'b1;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
            end else if (stk_uf) begin
               state_d = ST_DONE;
            end else begin
               state_d   = ST_SHOW;
               disp_d    = stk_rd_data;
               tmr_clr_s = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // state and display registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         disp_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         disp_q  <= disp_d;
         valid_q <= valid_d;
      end
   end

`ifdef STACK_DUMP_COUNT_EN
   logic             start_acc_s;
   logic [CNT_W-1:0] item_q;
   logic [CNT_W-1:0] item_d;

   assign start_acc_s = (state_q == ST_IDLE) && start && !abort;

   // pops issued this dump, saturating at all-ones
   always_comb begin
      item_d = item_q;
      if (start_acc_s) begin
         item_d = '0;
      end else if (pop_s && (item_q != {CNT_W{1'b1}})) begin
         item_d = item_q + CNT_W'(1);
      end else begin
         item_d = item_q;
      end
   end

   // item counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         item_q <= '0;
      end else begin
         item_q <= item_d;
      end
   end

   assign item_cnt = item_q;
`endif

   // pop strobe stays combinational so abort or underflow can suppress it in the same cycle
   assign stk_pop    = pop_s;
   assign disp_data  = disp_q;
   assign disp_valid = valid_q;
   assign busy       = is_busy(state_q);
   assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_stack_dump.sv
// Self-checking bench for stack_dump: table-driven dumps, random dumps and corner sequences
// against a cycle-index timeline model and a behavioural 16-deep stack.
module tb_stack_dump;

   localparam int DW  = 8;
   localparam int HT  = 4;
   localparam int HCW = 4;
   localparam int CW  = 5;
   localparam int PER = HT + 2;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          abort;
   logic [DW-1:0] stk_rd_data;
   logic          stk_uf;
   logic          stk_pop;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          busy;
   logic          done;
`ifdef STACK_DUMP_COUNT_EN
   logic [CW-1:0] item_cnt;
`endif

   stack_dump #(
      .DW         (DW),
      .HOLD_TICKS (HT),
      .HOLD_CW    (HCW),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .abort       (abort),
      .stk_rd_data (stk_rd_data),
      .stk_uf      (stk_uf),
      .stk_pop     (stk_pop),
      .disp_data   (disp_data),
      .disp_valid  (disp_valid),
      .busy        (busy),
      .done        (done)
`ifdef STACK_DUMP_COUNT_EN
      ,
      .item_cnt    (item_cnt)
`endif
   );

   always #5 clk = ~clk;

   // behavioural stack: depth = pushed - pops
   logic [DW-1:0] mem [16];
   int            pushed = 0;
   int            pops   = 0;
   int            depth_s;

   always @(posedge clk) begin
      if (stk_pop && (pushed != pops)) pops <= pops + 1;
   end

   always_comb begin
      depth_s     = pushed - pops;
      stk_uf      = (depth_s == 0);
      stk_rd_data = 8'h00;
      if (depth_s > 0) stk_rd_data = mem[4'(depth_s - 1)];
   end

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_disp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      mem[4'(pushed - pops)] = v;
      pushed++;
   endtask

   // one dump with n fresh entries; abort_at < 0 means never abort
   task automatic run_dump(input int n, input int abort_at, input bit noise,
                           output int got_pops, output int exp_pops);
      logic [DW-1:0] ent [16];
      logic [DW-1:0] v;
      int            t_end, c_end, p0, i, r;
      bit            ab, eb, ev, ed, ep;
      @(negedge clk);
      pushed = pops;
      for (int k = 0; k < n; k++) begin
         v = 8'($urandom);
         push(v);
         ent[n-1-k] = v;
      end
      p0    = pops;
      t_end = n * PER;
      ab    = (abort_at >= 0) && (abort_at < t_end);
      c_end = ab ? abort_at + 1 : t_end;
      exp_pops = 0;
      for (int k = 0; k < n; k++) begin
         if (!ab || (HT + k * PER < abort_at)) exp_pops++;
      end
      start = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= c_end; c++) begin
         @(negedge clk);
         abort = ab && (c == abort_at);
         start = (noise && (c < c_end)) ? 1'($urandom % 2) : 1'b0;
         #1;
         if (ab && (c > abort_at)) begin
            eb = 1'b0; ev = 1'b0; ed = 1'b0; ep = 1'b0;
         end else if (c < t_end) begin
            i = c / PER;
            r = c % PER;
            exp_disp = ent[i];
            eb = 1'b1; ev = 1'b1; ed = 1'b0;
            ep = (r == HT) && !(ab && (c == abort_at));
         end else begin
            eb = 1'b0; ev = (n > 0); ed = 1'b1; ep = 1'b0;
         end
         chk("busy", 32'(busy), 32'(eb));
         chk("disp_valid", 32'(disp_valid), 32'(ev));
         chk("disp_data", 32'(disp_data), 32'(exp_disp));
         chk("done", 32'(done), 32'(ed));
         chk("stk_pop", 32'(stk_pop), 32'(ep));
      end
      abort = 1'b0;
      start = 1'b0;
      got_pops = pops - p0;
      chk("pop_count", 32'(got_pops), 32'(exp_pops));
      chk("entries_left", 32'(pushed - pops), 32'(n - exp_pops));
`ifdef STACK_DUMP_COUNT_EN
      chk("item_cnt", 32'(item_cnt), 32'(exp_pops));
`endif
   endtask

   typedef struct {
      int n;
      int abort_at;
      bit noise;
      int exp_pops;
      int exp_left;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int got, expm, n, ab_at;
      vecs[0] = '{3, -1, 1'b0, 3, 0};  // basic LIFO dump
      vecs[1] = '{0, -1, 1'b0, 0, 0};  // empty dump
      vecs[2] = '{2, 10, 1'b0, 1, 1};  // abort in second POP
      vecs[3] = '{3, -1, 1'b1, 3, 0};  // start noise while busy
      vecs[4] = '{5, 2,  1'b1, 0, 5};  // abort in SHOW
      vecs[5] = '{4, 11, 1'b0, 2, 2};  // abort in SETTLE
      vecs[6] = '{5, -1, 1'b0, 5, 0};  // five entries drained

      reset_n  = 1'b0;
      start    = 1'b0;
      abort    = 1'b0;
      exp_disp = 8'h00;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(disp_valid), 32'd0);
      chk("rst_disp", 32'(disp_data), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pop", 32'(stk_pop), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int t = 0; t < 7; t++) begin
         run_dump(vecs[t].n, vecs[t].abort_at, vecs[t].noise, got, expm);
         chk("tbl_pops", 32'(got), 32'(vecs[t].exp_pops));
         chk("tbl_left", 32'(pushed - pops), 32'(vecs[t].exp_left));
      end
      // empty dump straight after a full one clears the count
      run_dump(0, -1, 1'b0, got, expm);

      for (int t = 0; t < 8; t++) begin
         n     = $urandom_range(0, 16);
         ab_at = ($urandom % 2 == 0) ? -1 : $urandom_range(0, n * PER);
         run_dump(n, ab_at, 1'b1, got, expm);
      end

      // start and abort together in IDLE: abort wins
      @(negedge clk);
      pushed = pops;
      push(8'hA5);
      push(8'h5A);
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      #1;
      chk("sa_busy", 32'(busy), 32'd0);
      chk("sa_done", 32'(done), 32'd0);
      @(negedge clk);
      #1;
      chk("sa_busy2", 32'(busy), 32'd0);
      chk("sa_left", 32'(pushed - pops), 32'd2);

      // asynchronous reset in the middle of SHOW
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk("pre_rst_busy", 32'(busy), 32'd1);
      chk("pre_rst_valid", 32'(disp_valid), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_valid", 32'(disp_valid), 32'd0);
      chk("async_disp", 32'(disp_data), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      chk("async_pop", 32'(stk_pop), 32'd0);
`ifdef STACK_DUMP_COUNT_EN
      chk("async_item_cnt", 32'(item_cnt), 32'd0);
`endif
      @(negedge clk);
      reset_n  = 1'b1;
      exp_disp = 8'h00;
      run_dump(3, -1, 1'b0, got, expm);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
